// File: rtl/sdrc_pkg.sv
// Shared SDRC command encodings and bus widths.
// Used by the refresh arbiter and by the cache's SDRAM command port.
package sdrc_pkg;

    typedef enum logic [2:0] {
        CMD_NOP          = 3'b111,
        CMD_AUTO_REFRESH = 3'b001,
        CMD_ACTIVATE     = 3'b011,
        CMD_WRITE        = 3'b100,
        CMD_READ         = 3'b101,
        CMD_PRECHARGE    = 3'b010
    } sdrc_cmd_e;

    localparam int SdrcAddrWidth = 21;
    localparam int SdrcLenWidth  = 8;

    // Counter width able to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/refresh_timer.sv
// Refresh obligation timer and pending-refresh bookkeeping.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   init_done_i         SDRC init done; the interval timer starts once seen
//   is_refresh_issued   one-cycle pulse: a refresh was issued (decrement)
//   pending_o           refreshes owed, saturating at MaxPendingRefreshes
//   refresh_overflow_o  sticky: an obligation arrived with pending saturated
module refresh_timer
    import sdrc_pkg::*;
#(
    parameter int RefreshIntervalCycles = 780,
    parameter int MaxPendingRefreshes   = 8,
    localparam int PendW = cnt_width(MaxPendingRefreshes + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init_done_i,
    input  logic             is_refresh_issued,
    output logic [PendW-1:0] pending_o,
    output logic             refresh_overflow_o
);

    localparam int               CntW    = cnt_width(RefreshIntervalCycles);
    localparam logic [CntW-1:0]  CntLast = CntW'(RefreshIntervalCycles - 1);
    localparam logic [PendW-1:0] PendMax = PendW'(MaxPendingRefreshes);

    logic             init_seen_q;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [PendW-1:0] pending_q, pending_d;
    logic             overflow_q, overflow_d;
    logic             run;
    logic             obligation;

    // The cycle that first shows init_done already counts.
    assign run        = init_seen_q | init_done_i;
    assign obligation = run && (cnt_q == CntLast);

    always_comb begin
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (run) begin
            cnt_d = obligation ? '0 : cnt_q + 1'b1;
        end
        // An obligation landing on the issue cycle cancels out.
        if (obligation && !is_refresh_issued) begin
            if (pending_q == PendMax) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end else if (!obligation && is_refresh_issued && (pending_q != '0)) begin
            pending_d = pending_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_seen_q <= 1'b0;
            cnt_q       <= '0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            init_seen_q <= run;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
        end
    end

    assign pending_o          = pending_q;
    assign refresh_overflow_o = overflow_q;

endmodule

// File: rtl/sdrc_refresh_arbiter.sv
// Owns the SDRC command port: interleaves periodic auto-refresh with whole
// cache transactions, forcing refresh ahead of the cache when debt is urgent.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   c_req_i / c_gnt_o               cache bus request (held per transaction) / grant
//   c_cmd_en_i, c_cmd_i, c_addr_i,  cache command port, passed through while granted
//   c_data_len_i
//   c_cmd_ack_o                     SDRC ack forwarded while granted, else 0
//   I_sdrc_*_o                      command outputs to the SDRC
//   O_sdrc_cmd_ack_i                SDRC command ack
//   O_sdrc_init_done_i              SDRC init complete
//   refresh_overflow_o              sticky: refresh debt saturated and overflowed
//   ack_timeout_o                   sticky: refresh ack never arrived
module sdrc_refresh_arbiter
    import sdrc_pkg::*;
#(
    parameter int RefreshIntervalCycles  = 780,
    parameter int MaxPendingRefreshes    = 8,
    parameter int UrgentPendingRefreshes = 4,
    parameter int RefreshRecoveryCycles  = 8,
    parameter int AckTimeoutCycles       = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     c_req_i,
    output logic                     c_gnt_o,
    input  logic                     c_cmd_en_i,
    input  logic [2:0]               c_cmd_i,
    input  logic [SdrcAddrWidth-1:0] c_addr_i,
    input  logic [SdrcLenWidth-1:0]  c_data_len_i,
    output logic                     c_cmd_ack_o,
    output logic                     I_sdrc_cmd_en_o,
    output logic [2:0]               I_sdrc_cmd_o,
    output logic [SdrcAddrWidth-1:0] I_sdrc_addr_o,
    output logic [SdrcLenWidth-1:0]  I_sdrc_data_len_o,
    input  logic                     O_sdrc_cmd_ack_i,
    input  logic                     O_sdrc_init_done_i,
    output logic                     refresh_overflow_o,
    output logic                     ack_timeout_o
);

    // state        | meaning
    // ST_INIT      | waiting for SDRC init done
    // ST_IDLE      | bus free; choose refresh or cache
    // ST_CACHE     | cache owns the bus for a whole transaction
    // ST_ISSUE     | one-cycle AutoRefresh command
    // ST_WAIT_ACK  | waiting for refresh ack, bounded by timeout
    // ST_GAP       | post-refresh recovery before next grant
    localparam logic [2:0] ST_INIT     = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_CACHE    = 3'd2;
    localparam logic [2:0] ST_ISSUE    = 3'd3;
    localparam logic [2:0] ST_WAIT_ACK = 3'd4;
    localparam logic [2:0] ST_GAP      = 3'd5;

    localparam int               PendW    = cnt_width(MaxPendingRefreshes + 1);
    localparam int               WaitW    = cnt_width(AckTimeoutCycles + 1);
    localparam int               GapW     = cnt_width(RefreshRecoveryCycles + 1);
    localparam logic [PendW-1:0] PendUrg  = PendW'(UrgentPendingRefreshes);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(AckTimeoutCycles - 1);
    localparam logic [GapW-1:0]  GapLast  = GapW'(RefreshRecoveryCycles - 1);

    logic [2:0]       state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
    logic             ack_timeout_q, ack_timeout_d;
    logic [PendW-1:0] pending;
    logic             refresh_issued;

    assign refresh_issued = (state_q == ST_ISSUE);

    refresh_timer #(
        .RefreshIntervalCycles (RefreshIntervalCycles),
        .MaxPendingRefreshes   (MaxPendingRefreshes)
    ) u_refresh_timer (
        .clk                (clk),
        .rst_n              (rst_n),
        .init_done_i        (O_sdrc_init_done_i),
        .is_refresh_issued  (refresh_issued),
        .pending_o          (pending),
        .refresh_overflow_o (refresh_overflow_o)
    );

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        ack_timeout_d = ack_timeout_q;
        case (state_q)
            ST_INIT: begin
                if (O_sdrc_init_done_i) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (pending >= PendUrg)    state_d = ST_ISSUE;
                else if (c_req_i)          state_d = ST_CACHE;
                else if (pending != '0)    state_d = ST_ISSUE;
            end
            ST_CACHE: begin
                if (!c_req_i) state_d = ST_IDLE;
            end
            ST_ISSUE: begin
                // The issue cycle counts as the first waited cycle, so the
                // timeout flag lands exactly AckTimeoutCycles after cmd_en.
                wait_cnt_d = WaitW'(1);
                state_d    = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (O_sdrc_cmd_ack_i) begin
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else if (wait_cnt_q >= WaitLast) begin
                    ack_timeout_d = 1'b1;
                    gap_cnt_d     = '0;
                    state_d       = ST_GAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q >= GapLast) state_d = ST_IDLE;
                else                      gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_INIT;
            wait_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            ack_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            ack_timeout_q <= ack_timeout_d;
        end
    end

    // Grant is a decode of the state register, so it follows c_req by a cycle.
    always_comb begin
        c_gnt_o = (state_q == ST_CACHE);
        if (state_q == ST_CACHE) begin
            I_sdrc_cmd_en_o   = c_cmd_en_i;
            I_sdrc_cmd_o      = c_cmd_i;
            I_sdrc_addr_o     = c_addr_i;
            I_sdrc_data_len_o = c_data_len_i;
            c_cmd_ack_o       = O_sdrc_cmd_ack_i;
        end else begin
            I_sdrc_cmd_en_o   = refresh_issued;
            I_sdrc_cmd_o      = refresh_issued ? CMD_AUTO_REFRESH : CMD_NOP;
            I_sdrc_addr_o     = '0;
            I_sdrc_data_len_o = '0;
            c_cmd_ack_o       = 1'b0;
        end
    end

    assign ack_timeout_o = ack_timeout_q;

endmodule

// File: tb/tb_sdrc_refresh_arbiter.sv
// Directed bench for sdrc_refresh_arbiter with a small SDRC ack model
// (ack two cycles after cmd_en). Edge indices below are counted from the
// clock edge just before init_done is raised.
module tb_sdrc_refresh_arbiter;
    import sdrc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        c_req, c_gnt, c_cmd_en, c_cmd_ack;
    logic [2:0]  c_cmd;
    logic [20:0] c_addr;
    logic [7:0]  c_len;
    logic        sd_cmd_en;
    logic [2:0]  sd_cmd;
    logic [20:0] sd_addr;
    logic [7:0]  sd_len;
    logic        sd_ack, init_done, ovf, ack_to;
    logic        ack_en, ack_d0, ack_d1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n, t_prev, cnt;

    always #5 clk = ~clk;

    sdrc_refresh_arbiter #(
        .RefreshIntervalCycles  (16),
        .MaxPendingRefreshes    (4),
        .UrgentPendingRefreshes (2),
        .RefreshRecoveryCycles  (4),
        .AckTimeoutCycles       (8)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .c_req_i            (c_req),
        .c_gnt_o            (c_gnt),
        .c_cmd_en_i         (c_cmd_en),
        .c_cmd_i            (c_cmd),
        .c_addr_i           (c_addr),
        .c_data_len_i       (c_len),
        .c_cmd_ack_o        (c_cmd_ack),
        .I_sdrc_cmd_en_o    (sd_cmd_en),
        .I_sdrc_cmd_o       (sd_cmd),
        .I_sdrc_addr_o      (sd_addr),
        .I_sdrc_data_len_o  (sd_len),
        .O_sdrc_cmd_ack_i   (sd_ack),
        .O_sdrc_init_done_i (init_done),
        .refresh_overflow_o (ovf),
        .ack_timeout_o      (ack_to)
    );

    // SDRC ack model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_d0 <= 1'b0;
            ack_d1 <= 1'b0;
        end else begin
            ack_d0 <= sd_cmd_en;
            ack_d1 <= ack_d0;
        end
    end
    assign sd_ack = ack_en & ack_d1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic sel(input int which);
        return (which == 0) ? sd_cmd_en : c_gnt;
    endfunction

    // Ticks until the selected output is high; n = edges taken (budget on expiry).
    task automatic wait_for(input int which, input int budget, output int nn);
        nn = 0;
        while (sel(which) !== 1'b1 && nn < budget) begin
            tick();
            nn++;
        end
    endtask

    // Reset, release, then raise init_done just after edge E0.
    task automatic start(input logic req, input logic ack_on);
        rst_n = 1'b0; init_done = 1'b0; c_req = 1'b0; c_cmd_en = 1'b0;
        c_cmd = CMD_NOP; c_addr = '0; c_len = '0; ack_en = ack_on;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        c_req = req;
        init_done = 1'b1;
    endtask

    initial begin
        // 1: reset values, idle refresh cadence
        start(1'b0, 1'b1);
        check_val("rst_gnt", c_gnt, 0);
        check_val("rst_cmd_en", sd_cmd_en, 0);
        check_val("rst_cmd", sd_cmd, 3'b111);
        check_val("rst_addr", sd_addr, 0);
        check_val("rst_len", sd_len, 0);
        check_val("rst_cmd_ack", c_cmd_ack, 0);
        check_val("rst_ovf", ovf, 0);
        check_val("rst_ack_to", ack_to, 0);
        wait_for(0, 40, n);
        check_val("t1_first_ref_edges", n, 17);
        check_val("t1_first_ref_cmd", sd_cmd, 3'b001);
        t_prev = cyc;
        tick();
        c_cmd_en = 1'b1; c_cmd = CMD_WRITE; c_addr = 21'h155;
        #1;
        check_val("t1_drop_cmd_en", sd_cmd_en, 0);
        check_val("t1_drop_addr", sd_addr, 0);
        c_cmd_en = 1'b0;
        tick();
        check_val("t1_no_fwd_ack", c_cmd_ack, 0);
        wait_for(0, 40, n);
        check_val("t1_period_a", cyc - t_prev, 16);
        t_prev = cyc;
        tick();
        wait_for(0, 40, n);
        check_val("t1_period_b", cyc - t_prev, 16);
        check_val("t1_ovf", ovf, 0);
        check_val("t1_ack_to", ack_to, 0);

        // 2: cache passthrough (now at E49, refresh issue cycle)
        c_req = 1'b1;
        wait_for(1, 40, n);
        check_val("t2_gnt_edges", n, 8);
        c_cmd_en = 1'b1; c_cmd = CMD_ACTIVATE; c_addr = 21'h1A400; c_len = 8'd0;
        #1;
        check_val("t2_act_en", sd_cmd_en, 1);
        check_val("t2_act_cmd", sd_cmd, 3'b011);
        check_val("t2_act_addr", sd_addr, 21'h1A400);
        tick();
        c_cmd_en = 1'b0;
        check_val("t2_ack_early", c_cmd_ack, 0);
        tick();
        check_val("t2_ack_fwd", c_cmd_ack, 1);
        c_cmd_en = 1'b1; c_cmd = CMD_READ; c_len = 8'd7;
        #1;
        check_val("t2_rd_en", sd_cmd_en, 1);
        check_val("t2_rd_cmd", sd_cmd, 3'b101);
        check_val("t2_rd_len", sd_len, 7);
        tick();
        c_cmd_en = 1'b0;
        tick();
        check_val("t2_rd_ack", c_cmd_ack, 1);
        check_val("t2_gnt_held", c_gnt, 1);
        c_req = 1'b0;
        tick();
        check_val("t2_gnt_drop", c_gnt, 0);

        // 3: urgent refresh preempts regrant
        start(1'b1, 1'b1);
        wait_for(1, 10, n);
        check_val("t3_gnt_edges", n, 2);
        for (int i = 0; i < 34; i++) tick();
        check_val("t3_gnt_e36", c_gnt, 1);
        check_val("t3_no_ref_in_cache", sd_cmd_en, 0);
        c_req = 1'b0;
        tick();
        check_val("t3_gnt_off", c_gnt, 0);
        c_req = 1'b1;
        tick();
        check_val("t3_urgent_en", sd_cmd_en, 1);
        check_val("t3_urgent_cmd", sd_cmd, 3'b001);
        check_val("t3_urgent_gnt", c_gnt, 0);
        wait_for(1, 40, n);
        check_val("t3_regrant_edges", n, 8);

        // 4: saturation and overflow
        start(1'b1, 1'b1);
        wait_for(1, 10, n);
        check_val("t4_gnt_edges", n, 2);
        for (int i = 0; i < 77; i++) tick();
        check_val("t4_ovf_e79", ovf, 0);
        tick();
        check_val("t4_ovf_e80", ovf, 1);
        for (int i = 0; i < 20; i++) tick();
        check_val("t4_gnt_e100", c_gnt, 1);
        check_val("t4_ovf_sticky", ovf, 1);
        c_req = 1'b0;
        wait_for(0, 10, n);
        check_val("t4_first_ref", n, 2);
        t_prev = cyc;
        for (int i = 0; i < 3; i++) begin
            tick();
            wait_for(0, 20, n);
            check_val($sformatf("t4_spacing_%0d", i), cyc - t_prev, 8);
            t_prev = cyc;
        end
        check_val("t4_ovf_end", ovf, 1);

        // 5: ack timeout
        start(1'b0, 1'b0);
        wait_for(0, 40, n);
        check_val("t5_ref_edges", n, 17);
        for (int i = 0; i < 7; i++) tick();
        check_val("t5_to_e24", ack_to, 0);
        tick();
        check_val("t5_to_e25", ack_to, 1);
        c_req = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_val("t5_gnt_e29", c_gnt, 0);
        tick();
        check_val("t5_gnt_e30", c_gnt, 1);

        // 6: reset while waiting for refresh ack
        tick();
        c_req = 1'b0;
        wait_for(0, 10, n);
        check_val("t6_ref_edges", n, 2);
        tick();
        c_addr = 21'h1FFFF; c_len = 8'hAA; init_done = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_cmd_en", sd_cmd_en, 0);
        check_val("t6_cmd", sd_cmd, 3'b111);
        check_val("t6_addr", sd_addr, 0);
        check_val("t6_len", sd_len, 0);
        check_val("t6_gnt", c_gnt, 0);
        check_val("t6_ack_to", ack_to, 0);
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sd_cmd_en === 1'b1) cnt++;
        end
        check_val("t6_quiet_no_init", cnt, 0);
        init_done = 1'b1;
        wait_for(0, 40, n);
        check_val("t6_ref_after_init", n, 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
